// File: rtl/rtr_alloc_pkg.sv
// Shared types and round-robin helper for the router output allocator.
// Also used by the input-side VC logic.
package rtr_alloc_pkg;

  localparam int RR_MAX = 32;

  typedef enum logic {IDLE, LOCKED} alloc_state_t;

  // First set bit of mask at or after ptr, cyclic over n bits.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] mask,
    input int                ptr,
    input int                n
  );
    logic [RR_MAX-1:0] oh;
    logic              found;
    int                idx;
    logic [4:0]        bi;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        bi = idx[4:0];
        if (!found && mask[bi]) begin
          oh[bi] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/rtr_output_allocator_if.sv
// Request/grant and credit bundle between route compute, crossbar and
// one output allocator.
interface rtr_output_allocator_if #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS),
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH+1)
);
  logic [NUM_INPUTS-1:0]   req;
  logic [NUM_INPUTS-1:0]   req_is_tail;
  logic [NUM_INPUTS-1:0]   disable_turn;
  logic                    credit_in;
  logic [NUM_INPUTS-1:0]   grant;
  logic                    send_out;
  logic [SEL_WIDTH-1:0]    sel_out;
  logic                    locked;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    credit_err;

  modport master (
    output req, req_is_tail, disable_turn, credit_in,
    input  grant, send_out, sel_out, locked, credits, credit_err
  );

  modport slave (
    input  req, req_is_tail, disable_turn, credit_in,
    output grant, send_out, sel_out, locked, credits, credit_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Parameterized round-robin one-hot picker; ptr is the highest-priority
// position for this cycle.
module rr_arbiter
  import rtr_alloc_pkg::*;
#(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [RR_MAX-1:0] wide_req;

  always_comb begin
    wide_req        = '0;
    wide_req[N-1:0] = req;
    gnt = N'(rr_pick(wide_req, int'(ptr), N));
  end

endmodule

// File: rtl/rtr_output_allocator.sv
// Per-output wormhole allocator: round-robin head arbitration, lock
// until tail, and downstream credit tracking.
module rtr_output_allocator
  import rtr_alloc_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS),
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH+1)
) (
  input  logic clk_noc,
  input  logic rst,
  rtr_output_allocator_if.slave bus
);

  localparam logic [CREDIT_WIDTH-1:0] FULL =
    CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [SEL_WIDTH-1:0] LAST =
    SEL_WIDTH'(NUM_INPUTS-1);

  alloc_state_t state, state_n;

  logic [SEL_WIDTH-1:0]    rr_ptr, rr_ptr_n;
  logic [SEL_WIDTH-1:0]    owner, owner_n;
  logic [SEL_WIDTH-1:0]    pick_idx, gnt_idx;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [NUM_INPUTS-1:0]   elig, pick, grant;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    any_grant, has_credit;
  logic                    send_q, credit_err;

  function automatic logic [SEL_WIDTH-1:0] wrap_inc(
    input logic [SEL_WIDTH-1:0] i
  );
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [SEL_WIDTH-1:0] oh_idx(
    input logic [NUM_INPUTS-1:0] oh
  );
    logic [SEL_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (oh[i]) r = r | SEL_WIDTH'(i);
    return r;
  endfunction

  assign elig       = bus.req & ~bus.disable_turn;
  assign has_credit = (credits != '0);
  assign any_grant  = |grant;
  assign pick_idx   = oh_idx(pick);
  assign gnt_idx    = oh_idx(grant);

  rr_arbiter #(
    .N  (NUM_INPUTS),
    .PW (SEL_WIDTH)
  ) u_rr (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    grant    = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (has_credit && |elig) begin
            grant = pick;
            if (|(pick & bus.req_is_tail)) begin
              rr_ptr_n = wrap_inc(pick_idx);
            end else begin
              state_n = LOCKED;
              owner_n = pick_idx;
            end
          end
        end
        LOCKED: begin
          // Turn mask was checked on the head; body flits follow it.
          if (has_credit && bus.req[owner]) begin
            grant[owner] = 1'b1;
            if (bus.req_is_tail[owner]) begin
              state_n  = IDLE;
              rr_ptr_n = wrap_inc(owner);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      credits    <= FULL;
      credit_err <= 1'b0;
      send_q     <= 1'b0;
      sel_q      <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      owner  <= owner_n;
      send_q <= any_grant;
      sel_q  <= gnt_idx;
      if (bus.credit_in && !any_grant) begin
        if (credits == FULL) credit_err <= 1'b1;
        else                 credits    <= credits + 1'b1;
      end else if (!bus.credit_in && any_grant) begin
        credits <= credits - 1'b1;
      end
    end
  end

  assign bus.grant      = grant;
  assign bus.send_out   = send_q;
  assign bus.sel_out    = sel_q;
  assign bus.locked     = (state == LOCKED);
  assign bus.credits    = credits;
  assign bus.credit_err = credit_err;

endmodule
